// File: rtl/game_state_ctrl.sv
// Game flow controller: debounced start key, frame-aligned scene changes,
// lives/invulnerability bookkeeping and timed end-screen hold.
module game_state_ctrl #(
  parameter int unsigned LIVES           = 3,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [7:0]  INVULN_FRAMES   = 8'd60,
  parameter logic [7:0]  HOLD_FRAMES     = 8'd180
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       key_start,
  input  logic       hit,
  input  logic       reach_goal,
  output logic [1:0] game_state,
  output logic [1:0] lives,
  output logic       invuln,
  output logic       state_changed
);

  typedef enum logic [1:0] {
    GS_INITIAL = 2'b00,
    GS_RUNNING = 2'b01,
    GS_OVER    = 2'b10,
    GS_SUCCESS = 2'b11
  } gstate_e;

  localparam logic [1:0] LIVES_INIT = 2'(LIVES);

  // ---------------- start key: synchronizer + debounce ----------------
  logic        sync1_q, sync2_q;
  logic [15:0] db_cnt_q, db_cnt_d;
  logic        db_lvl_q, db_lvl_d;
  logic        start_evt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      db_cnt_q <= '0;
      db_lvl_q <= 1'b0;
    end else begin
      sync1_q  <= key_start;
      sync2_q  <= sync1_q;
      db_cnt_q <= db_cnt_d;
      db_lvl_q <= db_lvl_d;
    end
  end

  // Counter runs only while the synchronized level disagrees; any agreement restarts it.
  always_comb begin
    db_cnt_d  = '0;
    db_lvl_d  = db_lvl_q;
    start_evt = 1'b0;
    if (sync2_q != db_lvl_q) begin
      if (db_cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
        db_lvl_d  = sync2_q;
        start_evt = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 16'd1;
      end
    end
  end

  // ---------------- game state machine ----------------
  gstate_e    gs_q, gs_d, ns_q, ns_d;
  logic [1:0] lives_q, lives_d;
  logic [7:0] inv_cnt_q, inv_cnt_d;
  logic [7:0] hold_q, hold_d;
  logic       sc_q, sc_d;
  logic       accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gs_q      <= GS_INITIAL;
      ns_q      <= GS_INITIAL;
      lives_q   <= LIVES_INIT;
      inv_cnt_q <= '0;
      hold_q    <= '0;
      sc_q      <= 1'b0;
    end else begin
      gs_q      <= gs_d;
      ns_q      <= ns_d;
      lives_q   <= lives_d;
      inv_cnt_q <= inv_cnt_d;
      hold_q    <= hold_d;
      sc_q      <= sc_d;
    end
  end

  always_comb begin
    gs_d      = gs_q;
    ns_d      = ns_q;
    lives_d   = lives_q;
    inv_cnt_d = inv_cnt_q;
    hold_d    = hold_q;
    // A frame_start resolves any pending request, so events in that cycle
    // are judged against the state being applied.
    accept    = (ns_q == gs_q) || frame_start;

    if (frame_start) begin
      gs_d = ns_q;
      if (inv_cnt_q != 8'd0) inv_cnt_d = inv_cnt_q - 8'd1;
      // Hold expiry applies straight away so the end screen lasts exactly HOLD_FRAMES.
      if (gs_q[1] && hold_q != 8'd0) begin
        hold_d = hold_q - 8'd1;
        if (hold_q == 8'd1) begin
          gs_d = GS_INITIAL;
          ns_d = GS_INITIAL;
        end
      end
    end

    if (accept) begin
      unique case (ns_q)
        GS_INITIAL: begin
          if (start_evt) begin
            ns_d    = GS_RUNNING;
            lives_d = LIVES_INIT;
          end
        end
        GS_RUNNING: begin
          if (reach_goal) begin
            ns_d = GS_SUCCESS;
          end else if (hit && inv_cnt_q == 8'd0 && lives_q != 2'd0) begin
            lives_d = lives_q - 2'd1;
            if (lives_q == 2'd1) ns_d = GS_OVER;
            else                 inv_cnt_d = INVULN_FRAMES;
          end
        end
        default: begin
          if (start_evt) ns_d = GS_INITIAL;
        end
      endcase
    end

    if (ns_d != GS_RUNNING) inv_cnt_d = '0;
    if (!gs_d[1])                  hold_d = '0;
    else if (!gs_q[1])             hold_d = HOLD_FRAMES;

    sc_d = (gs_d != gs_q);
  end

  assign game_state    = gs_q;
  assign lives         = lives_q;
  assign invuln        = (inv_cnt_q != 8'd0);
  assign state_changed = sc_q;

endmodule

// File: doc/game_state_ctrl.md
GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

Interface
REQ-001 Parameter: LIVES, default 3, lives loaded at game start (legal 1..3).
REQ-002 Parameter: DEBOUNCE_CYCLES, default 16'd50000, stable cycles required to accept a key level change (legal 1..65535).
REQ-003 Parameter: INVULN_FRAMES, default 8'd60, frames of hit immunity after a non-fatal hit (legal 1..255).
REQ-004 Parameter: HOLD_FRAMES, default 8'd180, frames GAME_OVER/GAME_SUCCESS are shown before returning to GAME_INITIAL (legal 1..255).
REQ-005 Ports: clock and reset. One clock; reset is asynchronous and active-low.
- clk  in  1  system/pixel clock.
- rst_n  in  1  asynchronous active-low reset.
REQ-006 Ports: inputs.
- frame_start  in  1  one-cycle pulse at start of each VGA frame (vertical blank).
- key_start  in  1  raw start pushbutton, active-high, asynchronous to clk.
- hit  in  1  one-cycle collision pulse (player vs barrel).
- reach_goal  in  1  one-cycle pulse when player reaches the goal.
REQ-007 Ports: outputs.
- game_state  out  2  00 INITIAL, 01 RUNNING, 10 OVER, 11 SUCCESS; drives the background/sprite colour selector.
- lives  out  2  remaining lives.
- invuln  out  1  high while hit immunity is active.
- state_changed  out  1  one-cycle pulse in the cycle after game_state updates.

Function
REQ-008 key_start SHALL pass a 2-flop synchronizer, then a debounce counter; the debounced level SHALL change only after DEBOUNCE_CYCLES consecutive cycles of a stable, differing synchronized level.
REQ-009 start_evt SHALL be a one-cycle pulse on each rising edge of the debounced level; holding the key SHALL produce exactly one start_evt.
REQ-010 Internal next_state register SHALL hold the requested state; game_state SHALL load next_state only in a cycle with frame_start=1, so the displayed scene never changes mid-frame.
REQ-011 While next_state != game_state (transition pending), hit, reach_goal and start_evt SHALL be ignored.
REQ-012 INITIAL: start_evt -> next_state=RUNNING and lives=LIVES, both in the same cycle.
REQ-013 RUNNING, reach_goal=1 -> next_state=SUCCESS; when hit and reach_goal arrive in the same cycle, reach_goal wins and lives are unchanged.
REQ-014 RUNNING, hit=1 with invuln=0 -> lives decrements by 1 in the next cycle; if lives was 1, lives becomes 0 and next_state=OVER; otherwise invuln=1 and the invulnerability counter loads INVULN_FRAMES.
REQ-015 RUNNING, hit=1 with invuln=1 SHALL be ignored; lives SHALL never wrap below 0.
REQ-016 The invulnerability counter SHALL decrement on each frame_start; invuln SHALL fall on the frame_start that takes the counter from 1 to 0; leaving RUNNING SHALL clear the counter and invuln.
REQ-017 The hold counter SHALL load HOLD_FRAMES when game_state becomes OVER or SUCCESS and SHALL decrement on each frame_start; at the frame_start where it reads 1, next_state=INITIAL.
REQ-018 OVER/SUCCESS, start_evt -> next_state=INITIAL immediately (skip remaining hold); the applied change SHALL still wait for frame_start.
REQ-019 state_changed SHALL pulse for exactly one cycle per game_state update and never otherwise.
REQ-020 frame_start coinciding with an event: game_state SHALL load the old next_state; the event is evaluated against that old next_state and takes effect at the following frame_start.
REQ-021 game_state value 11 after INITIAL SHALL only be reached via RUNNING; no direct INITIAL->OVER/SUCCESS path exists.

Reset
REQ-022 rst_n=0 SHALL asynchronously force: game_state=00, next_state=00, lives=LIVES, invuln=0, state_changed=0, all counters 0, synchronizer and debounced level 0.
REQ-023 Reset assertion mid-transition or mid-hold SHALL discard the pending state; the first output change after release requires a new start_evt.

Verification (DEBOUNCE_CYCLES=4, INVULN_FRAMES=3, HOLD_FRAMES=2, LIVES=3)
REQ-024 Key held 10 cycles, then frame_start -> one start_evt; game_state 00->01 on frame_start, lives=3, state_changed one pulse; a 3-cycle glitch produces nothing.
REQ-025 RUNNING, hit -> lives=2, invuln=1; second hit before 3 frame_starts ignored; invuln=0 after 3rd frame_start; third hit -> lives=1.
REQ-026 lives=1, hit -> lives=0, game_state=10 at next frame_start; after 2 more frame_starts game_state=00.
REQ-027 RUNNING, hit and reach_goal same cycle -> lives unchanged, game_state=11 at next frame_start; start_evt during SUCCESS -> 00 at next frame_start.
REQ-028 rst_n pulled low mid-frame while next_state=RUNNING -> outputs at reset values immediately; frame_start after release leaves game_state=00.
